// File: rtl/euler_frame_assembler_if.sv
// Byte-strobe input bus and filtered attitude outputs
// for the Euler frame assembler.
interface euler_frame_assembler_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte_addr;
  logic [7:0]  i_byte_data;
  logic [15:0] o_roll;
  logic [15:0] o_pitch;
  logic        o_frame_valid;
  logic        o_seq_error;
  logic        o_timeout;
  logic [7:0]  o_frame_count;

  modport master (
    output i_byte_valid, i_byte_addr, i_byte_data,
    input  o_roll, o_pitch, o_frame_valid,
    input  o_seq_error, o_timeout, o_frame_count
  );

  modport slave (
    input  i_byte_valid, i_byte_addr, i_byte_data,
    output o_roll, o_pitch, o_frame_valid,
    output o_seq_error, o_timeout, o_frame_count
  );
endinterface

// File: rtl/euler_frame_assembler.sv
// Collects roll/pitch register bytes into frames and
// smooths each axis with a power-of-two moving average.
module euler_frame_assembler #(
  parameter logic [7:0] BASE_ADDR      = 8'h1C,
  parameter int         AVG_LOG2       = 2,
  parameter int         TIMEOUT_CYCLES = 250000
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  euler_frame_assembler_if.slave bus
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    EXP_RL, EXP_RH, EXP_PL, EXP_PH
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [7:0] rl_q, rl_d, rh_q, rh_d, pl_q, pl_d;
  logic seq_err_q, seq_err_d, tmo_q, tmo_d;

  logic f_vld_q, f_vld_d;
  logic signed [15:0] roll_f_q, roll_f_d;
  logic signed [15:0] pitch_f_q, pitch_f_d;

  logic signed [15:0] rbuf_q [D];
  logic signed [15:0] rbuf_d [D];
  logic signed [15:0] pbuf_q [D];
  logic signed [15:0] pbuf_d [D];
  logic signed [SW-1:0] sr_q, sr_d, sp_q, sp_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic primed_q, primed_d;
  logic s_vld_q, s_vld_d;

  logic o_vld_q, o_vld_d;
  logic [15:0] roll_o_q, roll_o_d, pitch_o_q, pitch_o_d;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0] exp_addr;
  logic       hit;

  assign exp_addr = BASE_ADDR + {6'd0, state_q};
  assign hit = bus.i_byte_valid && (bus.i_byte_addr == exp_addr);

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    rl_d      = rl_q;
    rh_d      = rh_q;
    pl_d      = pl_q;
    seq_err_d = 1'b0;
    tmo_d     = 1'b0;
    f_vld_d   = 1'b0;
    roll_f_d  = roll_f_q;
    pitch_f_d = pitch_f_q;
    if (bus.i_byte_valid) begin
      idle_d = '0;
      if (hit) begin
        unique case (state_q)
          EXP_RL: begin
            rl_d    = bus.i_byte_data;
            state_d = EXP_RH;
          end
          EXP_RH: begin
            rh_d    = bus.i_byte_data;
            state_d = EXP_PL;
          end
          EXP_PL: begin
            pl_d    = bus.i_byte_data;
            state_d = EXP_PH;
          end
          EXP_PH: begin
            roll_f_d  = {rh_q, rl_q};
            pitch_f_d = {bus.i_byte_data, pl_q};
            f_vld_d   = 1'b1;
            state_d   = EXP_RL;
          end
        endcase
      end else begin
        // A stray roll-L byte restarts a frame instead of being lost
        seq_err_d = 1'b1;
        if (bus.i_byte_addr == BASE_ADDR) begin
          rl_d    = bus.i_byte_data;
          state_d = EXP_RH;
        end else begin
          state_d = EXP_RL;
        end
      end
    end else if (state_q == EXP_RL) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d  = '0;
      tmo_d   = 1'b1;
      state_d = EXP_RL;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    rbuf_d   = rbuf_q;
    pbuf_d   = pbuf_q;
    sr_d     = sr_q;
    sp_d     = sp_q;
    ptr_d    = ptr_q;
    primed_d = primed_q;
    s_vld_d  = f_vld_q;
    if (f_vld_q) begin
      if (!primed_q) begin
        for (int i = 0; i < D; i++) begin
          rbuf_d[i] = roll_f_q;
          pbuf_d[i] = pitch_f_q;
        end
        sr_d     = SW'(roll_f_q) <<< AVG_LOG2;
        sp_d     = SW'(pitch_f_q) <<< AVG_LOG2;
        primed_d = 1'b1;
      end else begin
        sr_d = sr_q + SW'(roll_f_q) - SW'(rbuf_q[ptr_q]);
        sp_d = sp_q + SW'(pitch_f_q) - SW'(pbuf_q[ptr_q]);
        rbuf_d[ptr_q] = roll_f_q;
        pbuf_d[ptr_q] = pitch_f_q;
        ptr_d = (ptr_q == PW'(D - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_vld_d   = s_vld_q;
    roll_o_d  = roll_o_q;
    pitch_o_d = pitch_o_q;
    cnt_d     = cnt_q;
    if (s_vld_q) begin
      roll_o_d  = 16'(sr_q >>> AVG_LOG2);
      pitch_o_d = 16'(sp_q >>> AVG_LOG2);
      cnt_d     = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= EXP_RL;
      idle_q    <= '0;
      rl_q      <= '0;
      rh_q      <= '0;
      pl_q      <= '0;
      seq_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      f_vld_q   <= 1'b0;
      roll_f_q  <= '0;
      pitch_f_q <= '0;
      rbuf_q    <= '{default: '0};
      pbuf_q    <= '{default: '0};
      sr_q      <= '0;
      sp_q      <= '0;
      ptr_q     <= '0;
      primed_q  <= 1'b0;
      s_vld_q   <= 1'b0;
      o_vld_q   <= 1'b0;
      roll_o_q  <= '0;
      pitch_o_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      rl_q      <= rl_d;
      rh_q      <= rh_d;
      pl_q      <= pl_d;
      seq_err_q <= seq_err_d;
      tmo_q     <= tmo_d;
      f_vld_q   <= f_vld_d;
      roll_f_q  <= roll_f_d;
      pitch_f_q <= pitch_f_d;
      rbuf_q    <= rbuf_d;
      pbuf_q    <= pbuf_d;
      sr_q      <= sr_d;
      sp_q      <= sp_d;
      ptr_q     <= ptr_d;
      primed_q  <= primed_d;
      s_vld_q   <= s_vld_d;
      o_vld_q   <= o_vld_d;
      roll_o_q  <= roll_o_d;
      pitch_o_q <= pitch_o_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.o_roll        = roll_o_q;
  assign bus.o_pitch       = pitch_o_q;
  assign bus.o_frame_valid = o_vld_q;
  assign bus.o_seq_error   = seq_err_q;
  assign bus.o_timeout     = tmo_q;
  assign bus.o_frame_count = cnt_q;

endmodule

// File: tb/tb_euler_frame_assembler.sv
// Scoreboard bench: a queue-based reference model predicts
// frames, sequence errors and timeouts with their cycles.
module tb_euler_frame_assembler;

  localparam int         TC   = 40;
  localparam int         AL   = 2;
  localparam int         N    = 1 << AL;
  localparam logic [7:0] BASE = 8'h1C;

  typedef struct {
    int          cyc;
    logic [15:0] r;
    logic [15:0] p;
    logic [7:0]  c;
  } fexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  euler_frame_assembler_if bus();

  euler_frame_assembler #(
    .BASE_ADDR(BASE),
    .AVG_LOG2(AL),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fexp_t fq[$];
  int    sq[$];
  int    tq[$];
  int    pend[$];
  int    hr[$];
  int    hp[$];
  int    idle_m = 0;
  int    frames_m = 0;
  logic [15:0] hold_r = '0;
  logic [15:0] hold_p = '0;
  logic [7:0]  hold_c = '0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int fdiv(int s);
    int q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q--;
    return q;
  endfunction

  function automatic int avg_push(inout int h[$], input int x);
    int s;
    if (h.size() == 0)
      for (int i = 0; i < N; i++) h.push_back(x);
    h.push_back(x);
    while (h.size() > N) void'(h.pop_front());
    s = 0;
    foreach (h[i]) s += h[i];
    return fdiv(s);
  endfunction

  task automatic model_frame(input int e);
    logic signed [15:0] rs, ps;
    fexp_t fe;
    rs = 16'(pend[1] * 256 + pend[0]);
    ps = 16'(pend[3] * 256 + pend[2]);
    frames_m = (frames_m + 1) % 256;
    fe.cyc = e + 2;
    fe.r   = 16'(avg_push(hr, int'(rs)));
    fe.p   = 16'(avg_push(hp, int'(ps)));
    fe.c   = 8'(frames_m);
    fq.push_back(fe);
  endtask

  // Model one clock edge e given the strobe presented to it
  task automatic model_step(input bit v, input logic [7:0] a,
                            input logic [7:0] d);
    int e;
    e = cyc + 1;
    if (v) begin
      idle_m = 0;
      if (int'(a) == int'(BASE) + pend.size()) begin
        pend.push_back(int'(d));
        if (pend.size() == 4) begin
          model_frame(e);
          pend.delete();
        end
      end else begin
        sq.push_back(e);
        pend.delete();
        if (a == BASE) pend.push_back(int'(d));
      end
    end else if (pend.size() > 0) begin
      idle_m++;
      if (idle_m == TC) begin
        tq.push_back(e);
        pend.delete();
        idle_m = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    bus.i_byte_valid = v;
    bus.i_byte_addr  = a;
    bus.i_byte_data  = d;
    model_step(v, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic frame(input logic [15:0] r, input logic [15:0] p);
    step(1'b1, BASE,        r[7:0]);
    step(1'b1, BASE + 8'd1, r[15:8]);
    step(1'b1, BASE + 8'd2, p[7:0]);
    step(1'b1, BASE + 8'd3, p[15:8]);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_roll"},  bus.o_roll, 0);
    chk({tag, "_pitch"}, bus.o_pitch, 0);
    chk({tag, "_fv"},    bus.o_frame_valid, 0);
    chk({tag, "_se"},    bus.o_seq_error, 0);
    chk({tag, "_to"},    bus.o_timeout, 0);
    chk({tag, "_cnt"},   bus.o_frame_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_byte_valid = 1'b0;
    fq.delete(); sq.delete(); tq.delete();
    pend.delete(); hr.delete(); hp.delete();
    idle_m = 0; frames_m = 0;
    hold_r = '0; hold_p = '0; hold_c = '0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    fexp_t fe;
    if (rst_n) begin
      if (bus.o_frame_valid) begin
        if (fq.size() == 0) begin
          chk("frame_unexpected", 1, 0);
        end else begin
          fe = fq.pop_front();
          chk("frame_cycle", cyc, fe.cyc);
          chk("frame_roll",  bus.o_roll, fe.r);
          chk("frame_pitch", bus.o_pitch, fe.p);
          chk("frame_count", bus.o_frame_count, fe.c);
          hold_r = fe.r; hold_p = fe.p; hold_c = fe.c;
        end
      end else begin
        if (fq.size() > 0 && fq[0].cyc < cyc) begin
          chk("frame_missing", 0, 1);
          fe = fq.pop_front();
          hold_r = fe.r; hold_p = fe.p; hold_c = fe.c;
        end
        chk("hold_roll",  bus.o_roll, hold_r);
        chk("hold_pitch", bus.o_pitch, hold_p);
        chk("hold_count", bus.o_frame_count, hold_c);
      end
      if (bus.o_seq_error) begin
        if (sq.size() == 0) chk("seq_unexpected", 1, 0);
        else chk("seq_cycle", cyc, sq.pop_front());
      end else if (sq.size() > 0 && sq[0] < cyc) begin
        chk("seq_missing", 0, 1);
        void'(sq.pop_front());
      end
      if (bus.o_timeout) begin
        if (tq.size() == 0) chk("tmo_unexpected", 1, 0);
        else chk("tmo_cycle", cyc, tq.pop_front());
      end else if (tq.size() > 0 && tq[0] < cyc) begin
        chk("tmo_missing", 0, 1);
        void'(tq.pop_front());
      end
    end
  end

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte_addr  = '0;
    bus.i_byte_data  = '0;
    #2;
    chk_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // first frame after reset
    frame(16'h0010, 16'hFFF0);
    idle(3);
    chk("d_roll",  bus.o_roll, 16'h0010);
    chk("d_pitch", bus.o_pitch, 16'hFFF0);
    chk("d_cnt",   bus.o_frame_count, 1);

    // averaging and floor rounding
    do_reset();
    frame(16, 0); frame(16, 0); frame(16, 0); frame(80, 0);
    idle(3);
    chk("d_avg32", bus.o_roll, 32);
    do_reset();
    frame(16'hFFFF, 0); frame(16'hFFFE, 0);
    idle(3);
    chk("d_floor", bus.o_roll, 16'hFFFE);

    // restart on repeated roll-L
    step(1'b1, 8'h1C, 8'h11); step(1'b1, 8'h1D, 8'h22);
    step(1'b1, 8'h1C, 8'h33); step(1'b1, 8'h1D, 8'h44);
    step(1'b1, 8'h1E, 8'h55); step(1'b1, 8'h1F, 8'h66);
    idle(3);
    // wrong address while waiting for roll-L
    step(1'b1, 8'h1F, 8'h01);
    idle(2);

    // timeout, then normal frame
    step(1'b1, 8'h1C, 8'h01); step(1'b1, 8'h1D, 8'h02);
    idle(TC + 5);
    frame(16'h0123, 16'h8000);
    idle(3);
    // byte arriving on the timeout edge wins
    step(1'b1, 8'h1C, 8'h05); step(1'b1, 8'h1D, 8'h06);
    idle(TC - 1);
    step(1'b1, 8'h1E, 8'h07); step(1'b1, 8'h1F, 8'h08);
    idle(3);

    // back-to-back frames, then resets mid-frame / mid-pipeline
    do_reset();
    frame(100, -100); frame(200, -200); frame(300, -300);
    idle(3);
    chk("d_b2b_cnt", bus.o_frame_count, 3);
    step(1'b1, 8'h1C, 8'h10); step(1'b1, 8'h1D, 8'h20);
    do_reset();
    chk_zero("after_rst");
    step(1'b1, 8'h1E, 8'h30); step(1'b1, 8'h1F, 8'h40);
    idle(4);
    frame(7, 8);
    do_reset();
    idle(4);
    chk_zero("pipe_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        idle(TC + $urandom_range(0, 3) - 2);
      end else if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 7) == 0)
          step(1'b1, BASE - 8'd1 + 8'($urandom_range(0, 5)),
               8'($urandom));
        else
          step(1'b1, BASE + 8'(pend.size()), 8'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(4);

    // frame counter wrap
    do_reset();
    for (int i = 0; i < 256; i++)
      frame(16'($urandom), 16'($urandom));
    idle(4);
    chk("d_wrap", bus.o_frame_count, 0);

    idle(4);
    chk("left_frames", fq.size(), 0);
    chk("left_seq",    sq.size(), 0);
    chk("left_tmo",    tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/euler_frame_assembler.md
EULER_FRAME_ASSEMBLER -- requirements
Module: euler_frame_assembler

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h1C, meaning register address of the roll LSB; frame bytes are BASE_ADDR..BASE_ADDR+3 = roll L, roll H, pitch L, pitch H.
REQ-002 SHALL have parameter AVG_LOG2, default 2, meaning moving-average window of 2^AVG_LOG2 frames; legal range 0..3.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000, meaning the idle limit in clocks for a partial frame (10 ms at 25 MHz).
REQ-004 i_clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_byte_valid  input  1  one-cycle strobe from the I2C read sequencer: the byte is complete.
REQ-007 i_byte_addr  input  8  register address of the strobed byte.
REQ-008 i_byte_data  input  8  register data of the strobed byte.
REQ-009 o_roll  output  16  filtered roll, signed two's complement, 1/16 degree LSB.
REQ-010 o_pitch  output  16  filtered pitch, same format.
REQ-011 o_frame_valid  output  1  one-cycle pulse when o_roll/o_pitch update.
REQ-012 o_seq_error  output  1  one-cycle pulse when an out-of-order address is received.
REQ-013 o_timeout  output  1  one-cycle pulse when a partial frame is abandoned.
REQ-014 o_frame_count  output  8  count of completed frames; wraps 255->0.

Function
REQ-015 Collector FSM SHALL have states EXP_RL, EXP_RH, EXP_PL, EXP_PH, expecting address BASE_ADDR+0..+3 respectively.
REQ-016 On i_byte_valid with the expected address, the FSM SHALL store the byte and advance; EXP_PH advances to EXP_RL and completes the frame.
REQ-017 On i_byte_valid with an unexpected address in any state, the FSM SHALL discard the partial frame and pulse o_seq_error in the next cycle.
REQ-018 After the REQ-017 discard, the FSM SHALL store the byte and go to EXP_RH when the address equals BASE_ADDR; otherwise it SHALL go to EXP_RL.
REQ-019 In EXP_RL, a wrong address SHALL also raise o_seq_error.
REQ-020 The idle counter SHALL clear on every i_byte_valid and while in EXP_RL, and increment otherwise.
REQ-021 When the idle counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to EXP_RL, discard the partial bytes, and pulse o_timeout once.
REQ-022 When the timeout and i_byte_valid occur in the same cycle, the byte SHALL win: there is no timeout, and the byte is processed per REQ-016..018.
REQ-023 Samples SHALL be assembled little-endian as {H, L} and treated as signed 16-bit.
REQ-024 The filter SHALL use per-axis ring buffers of depth 2^AVG_LOG2 and running sums of width 16+AVG_LOG2, signed.
REQ-025 Each frame SHALL update each running sum as sum + new - oldest, replace the oldest entry, and advance the write pointer, wrapping at the buffer depth.
REQ-026 The first frame after reset (primed flag clear) SHALL load every buffer entry with the new sample and the sum with sample<<AVG_LOG2, then set primed.
REQ-027 Each output SHALL be sum >>> AVG_LOG2 (arithmetic shift, floor toward minus infinity); with AVG_LOG2 = 0 the output is the raw sample.
REQ-028 Latency: if the pitch-H byte is accepted at edge T, the frame registers at T, the sums update at T+1, and o_roll/o_pitch/o_frame_valid update at T+2.
REQ-029 o_frame_valid SHALL be high for exactly the cycle after T+2, and o_frame_count SHALL increment at T+2.
REQ-030 The block SHALL accept back-to-back i_byte_valid strobes (one byte per cycle); a frame completing while the previous frame is in the pipeline SHALL not be lost.
REQ-031 Outputs SHALL hold their values between frames, and error and timeout events SHALL not alter the filter state.

Reset
REQ-032 While i_rst_n = 0, the block SHALL asynchronously clear: state EXP_RL, idle counter 0, ring buffers 0, sums 0, pointers 0, primed 0, and the pipeline valid bits 0.
REQ-033 While i_rst_n = 0, every output SHALL be 0.
REQ-034 Reset asserted mid-frame or mid-pipeline SHALL discard all in-flight data, with no o_frame_valid pulse after release.
REQ-035 Release of reset SHALL be synchronised to i_clk by the system; the block needs no deassertion logic of its own.

Verification
REQ-036 Bytes 0x1C=0x10, 0x1D=0x00, 0x1E=0xF0, 0x1F=0xFF after reset -> o_roll=0x0010, o_pitch=0xFFF0, o_frame_valid 2 cycles after the last byte, o_frame_count=1.
REQ-037 Roll frames 16, 16, 16, 80 (AVG_LOG2=2) -> o_roll = 16, 16, 16, 32; roll frames -1, then -2 -> o_roll = -1, then -2 (floor of -5/4).
REQ-038 Address sequence 0x1C, 0x1D, 0x1C, 0x1D, 0x1E, 0x1F -> one o_seq_error pulse after the third byte; a single frame completes using the second 0x1C/0x1D bytes.
REQ-039 0x1C, 0x1D, then no strobe for TIMEOUT_CYCLES -> one o_timeout pulse, no frame, and the next full frame is accepted normally.
REQ-040 Four bytes on consecutive cycles for 3 frames -> 3 o_frame_valid pulses and o_frame_count=3; reset pulse between bytes 2 and 3 -> all outputs 0 and no o_frame_valid.
REQ-041 Frame count wrap: 256 frames -> o_frame_count returns to 0.
